// File: rtl/mbist_march_ctrl_pkg.sv
// Shared MBIST definitions: march controller state encoding and default
// element/operation counts.
package mbist_march_ctrl_pkg;

    localparam int unsigned BIST_OP_SIZE = 4;
    localparam int unsigned BIST_STI_CNT = 5;
    localparam int unsigned BIST_STI_WD  = $clog2(BIST_STI_CNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_REPAIR,
        ST_DONE
    } mbist_state_e;

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down test-address counter with an element-boundary flag.
module mbist_addr_gen #(
    parameter int unsigned                 BIST_ADDR_WD    = 9,
    parameter logic [BIST_ADDR_WD-1:0]     BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0]     BIST_ADDR_END   = 9'h1F8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic                    up,
    output logic [BIST_ADDR_WD-1:0] addr,
    output logic                    at_bound
);

    logic [BIST_ADDR_WD-1:0] addr_q;
    logic [BIST_ADDR_WD-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = up ? BIST_ADDR_START : BIST_ADDR_END;
        end else if (step) begin
            addr_d = up ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BIST_ADDR_START;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign at_bound = up ? (addr_q == BIST_ADDR_END) : (addr_q == BIST_ADDR_START);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March-test sequencing FSM: steps elements and addresses, handles element
// repeat and repair-driven re-runs, and keeps sticky done/correct/error status.
module mbist_march_ctrl #(
    parameter int unsigned             BIST_ADDR_WD    = 9,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
    parameter int unsigned             BIST_STI_CNT    = mbist_march_ctrl_pkg::BIST_STI_CNT,
    parameter int unsigned             BIST_OP_SIZE    = mbist_march_ctrl_pkg::BIST_OP_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bist_start,
    input  logic                            scan_shift,
    input  logic                            last_op,
    input  logic                            op_updown,
    input  logic                            op_repeatflag,
    input  logic                            cmp_err,
    input  logic                            repair_ok,
    output logic                            run,
    output logic                            re_init,
    output logic [$clog2(BIST_STI_CNT)-1:0] sti_idx,
    output logic [BIST_ADDR_WD-1:0]         bist_addr,
    output logic                            bist_done,
    output logic                            bist_correct,
    output logic                            bist_error
);

    import mbist_march_ctrl_pkg::*;

    localparam int unsigned STI_WD = $clog2(BIST_STI_CNT);

    // The operation count only sizes the external selector; reject degenerate builds.
    if (BIST_OP_SIZE == 0 || BIST_STI_CNT < 2) begin : g_bad_param
        $error("mbist_march_ctrl: BIST_OP_SIZE must be >0 and BIST_STI_CNT >=2");
    end

    mbist_state_e      state_q, state_d;
    logic [STI_WD-1:0] sti_q, sti_d;
    logic              repeat_pass_q, repeat_pass_d;
    logic              done_q, done_d;
    logic              correct_q, correct_d;
    logic              error_q, error_d;
    logic              addr_load;
    logic              addr_step;
    logic              at_bound;

    always_comb begin
        state_d       = state_q;
        sti_d         = sti_q;
        repeat_pass_d = repeat_pass_q;
        done_d        = done_q;
        correct_d     = correct_q;
        error_d       = error_q;
        addr_load     = 1'b0;
        addr_step     = 1'b0;
        if (!scan_shift) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bist_start) begin
                        state_d       = ST_INIT;
                        sti_d         = '0;
                        repeat_pass_d = 1'b0;
                        done_d        = 1'b0;
                        correct_d     = 1'b0;
                        error_d       = 1'b0;
                    end
                end
                ST_INIT: begin
                    addr_load = 1'b1;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    // An error on the last op blocks the advance so the address re-runs.
                    if (cmp_err && repair_ok) begin
                        state_d   = ST_REPAIR;
                        correct_d = 1'b1;
                    end else if (cmp_err) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else if (last_op) begin
                        if (!at_bound) begin
                            addr_step = 1'b1;
                        end else if (op_repeatflag && !repeat_pass_q) begin
                            repeat_pass_d = 1'b1;
                            state_d       = ST_INIT;
                        end else if (sti_q == STI_WD'(BIST_STI_CNT - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            sti_d         = sti_q + 1'b1;
                            repeat_pass_d = 1'b0;
                            state_d       = ST_INIT;
                        end
                    end
                end
                ST_REPAIR: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sti_q         <= '0;
            repeat_pass_q <= 1'b0;
            done_q        <= 1'b0;
            correct_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sti_q         <= sti_d;
            repeat_pass_q <= repeat_pass_d;
            done_q        <= done_d;
            correct_q     <= correct_d;
            error_q       <= error_d;
        end
    end

    mbist_addr_gen #(
        .BIST_ADDR_WD    (BIST_ADDR_WD),
        .BIST_ADDR_START (BIST_ADDR_START),
        .BIST_ADDR_END   (BIST_ADDR_END)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_load),
        .step     (addr_step),
        .up       (op_updown),
        .addr     (bist_addr),
        .at_bound (at_bound)
    );

    assign run          = !scan_shift && (state_q == ST_RUN);
    assign re_init      = !scan_shift && (state_q == ST_REPAIR);
    assign sti_idx      = sti_q;
    assign bist_done    = done_q;
    assign bist_correct = correct_q;
    assign bist_error   = error_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed, table-driven bench for mbist_march_ctrl with a small operation
// selector and fault-injection environment around the DUT.
module tb_mbist_march_ctrl;

    localparam int OP_SIZE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bist_start = 1'b0;
    logic       scan_shift = 1'b0;
    logic       last_op;
    logic       op_updown;
    logic       op_repeatflag;
    logic       cmp_err;
    logic       repair_ok;
    logic       run;
    logic       re_init;
    logic [0:0] sti_idx;
    logic [8:0] bist_addr;
    logic       bist_done;
    logic       bist_correct;
    logic       bist_error;

    logic [1:0] dir_cfg;
    logic [1:0] rep_cfg;
    logic       err_en;
    logic [8:0] err_addr;
    int         err_op;
    logic       err_rep;
    logic       err_fired;
    int         op;

    int errors = 0;
    int checks = 0;

    mbist_march_ctrl #(
        .BIST_ADDR_WD    (9),
        .BIST_ADDR_START (9'h000),
        .BIST_ADDR_END   (9'h003),
        .BIST_STI_CNT    (2),
        .BIST_OP_SIZE    (OP_SIZE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bist_start    (bist_start),
        .scan_shift    (scan_shift),
        .last_op       (last_op),
        .op_updown     (op_updown),
        .op_repeatflag (op_repeatflag),
        .cmp_err       (cmp_err),
        .repair_ok     (repair_ok),
        .run           (run),
        .re_init       (re_init),
        .sti_idx       (sti_idx),
        .bist_addr     (bist_addr),
        .bist_done     (bist_done),
        .bist_correct  (bist_correct),
        .bist_error    (bist_error)
    );

    always #5 clk = ~clk;

    // Operation selector stand-in: counts ops per address, rewound by re_init.
    always @(posedge clk or posedge rst) begin
        if (rst)          op <= 0;
        else if (re_init) op <= 0;
        else if (run)     op <= (op == OP_SIZE - 1) ? 0 : op + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)          err_fired <= 1'b0;
        else if (cmp_err) err_fired <= 1'b1;
    end

    assign last_op       = (op == OP_SIZE - 1);
    assign op_updown     = dir_cfg[sti_idx];
    assign op_repeatflag = rep_cfg[sti_idx];
    assign cmp_err       = err_en && run && !err_fired && (bist_addr == err_addr) && (op == err_op);
    assign repair_ok     = err_rep;

    typedef struct {
        int         scn;
        int         cyc;
        logic       run;
        logic       re_init;
        logic [0:0] sti;
        logic [8:0] addr;
        logic       done;
        logic       corr;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input int scn, input int cyc, input bit r, input bit ri,
                              input int sti, input int addr, input bit d, input bit c, input bit e);
        vec_t x;
        x.scn = scn;  x.cyc = cyc;  x.run = r;  x.re_init = ri;
        x.sti = 1'(sti);  x.addr = 9'(addr);
        x.done = d;  x.corr = c;  x.err = e;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic ri, input logic [0:0] s,
                           input logic [8:0] a, input logic d, input logic c, input logic e);
        chk({tag, ".run"},     16'(run),          16'(r));
        chk({tag, ".re_init"}, 16'(re_init),      16'(ri));
        chk({tag, ".sti_idx"}, 16'(sti_idx),      16'(s));
        chk({tag, ".addr"},    16'(bist_addr),    16'(a));
        chk({tag, ".done"},    16'(bist_done),    16'(d));
        chk({tag, ".correct"}, 16'(bist_correct), 16'(c));
        chk({tag, ".error"},   16'(bist_error),   16'(e));
    endtask

    // Start pulse at cycle 0; optional extra start pulse, scan window and mid-cycle reset.
    task automatic run_scn(input int scn, input int ncyc, input int extra_start,
                           input int scan_s, input int scan_n, input int rst_c);
        rst        = 1'b1;
        bist_start = 1'b0;
        scan_shift = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            bist_start = (c == 0) || (c == extra_start);
            scan_shift = (c >= scan_s) && (c < scan_s + scan_n);
            @(negedge clk);
            foreach (tbl[i]) begin
                if (tbl[i].scn == scn && tbl[i].cyc == c) begin
                    chk_all($sformatf("s%0d.c%0d", scn, c), tbl[i].run, tbl[i].re_init, tbl[i].sti,
                            tbl[i].addr, tbl[i].done, tbl[i].corr, tbl[i].err);
                end
            end
            if (c == rst_c) begin
                #1 rst = 1'b1;
                #1 chk_all($sformatf("s%0d.async_rst", scn), 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
                #1 rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bist_start = 1'b0;
        scan_shift = 1'b0;
    endtask

    initial begin
        // scn 0: clean ascending run; stray start at cycle 5 must be ignored
        v(0, 0, 0,0,0,0, 0,0,0);  v(0, 1, 0,0,0,0, 0,0,0);  v(0, 2, 1,0,0,0, 0,0,0);
        v(0, 5, 1,0,0,1, 0,0,0);  v(0, 6, 1,0,0,2, 0,0,0);  v(0, 9, 1,0,0,3, 0,0,0);
        v(0,10, 0,0,1,3, 0,0,0);  v(0,11, 1,0,1,0, 0,0,0);  v(0,18, 1,0,1,3, 0,0,0);
        v(0,19, 0,0,1,3, 1,0,0);  v(0,22, 0,0,1,3, 1,0,0);
        // scn 1: element 1 descending
        v(1,10, 0,0,1,3, 0,0,0);  v(1,11, 1,0,1,3, 0,0,0);  v(1,13, 1,0,1,2, 0,0,0);
        v(1,16, 1,0,1,1, 0,0,0);  v(1,18, 1,0,1,0, 0,0,0);  v(1,19, 0,0,1,0, 1,0,0);
        // scn 2: element 0 repeated
        v(2, 9, 1,0,0,3, 0,0,0);  v(2,10, 0,0,0,3, 0,0,0);  v(2,11, 1,0,0,0, 0,0,0);
        v(2,18, 1,0,0,3, 0,0,0);  v(2,19, 0,0,1,3, 0,0,0);  v(2,20, 1,0,1,0, 0,0,0);
        v(2,27, 1,0,1,3, 0,0,0);  v(2,28, 0,0,1,3, 1,0,0);
        // scn 3: repairable error at address 2, op 1
        v(3, 7, 1,0,0,2, 0,0,0);  v(3, 8, 0,1,0,2, 0,1,0);  v(3, 9, 1,0,0,2, 0,1,0);
        v(3,10, 1,0,0,2, 0,1,0);  v(3,11, 1,0,0,3, 0,1,0);  v(3,13, 0,0,1,3, 0,1,0);
        v(3,21, 1,0,1,3, 0,1,0);  v(3,22, 0,0,1,3, 1,1,0);
        // scn 4: unrepairable error at address 1, then restart from DONE at cycle 8
        v(4, 5, 1,0,0,1, 0,0,0);  v(4, 6, 0,0,0,1, 1,0,1);  v(4, 8, 0,0,0,1, 1,0,1);
        v(4, 9, 0,0,0,1, 0,0,0);  v(4,10, 1,0,0,0, 0,0,0);
        // scn 5: scan_shift held cycles 5..9
        v(5, 5, 0,0,0,1, 0,0,0);  v(5, 9, 0,0,0,1, 0,0,0);  v(5,10, 1,0,0,1, 0,0,0);
        v(5,11, 1,0,0,2, 0,0,0);  v(5,23, 1,0,1,3, 0,0,0);  v(5,24, 0,0,1,3, 1,0,0);
        // scn 6: repair run, then async reset mid-element 1
        v(6,17, 1,0,1,1, 0,1,0);  v(6,18, 0,0,0,0, 0,0,0);  v(6,19, 0,0,0,0, 0,0,0);

        err_en = 1'b0;  err_addr = 9'd0;  err_op = 0;  err_rep = 1'b0;

        dir_cfg = 2'b11;  rep_cfg = 2'b00;
        run_scn(0, 23, 5, -1, 0, -1);

        dir_cfg = 2'b01;
        run_scn(1, 20, -1, -1, 0, -1);

        dir_cfg = 2'b11;  rep_cfg = 2'b01;
        run_scn(2, 30, -1, -1, 0, -1);

        rep_cfg = 2'b00;
        err_en = 1'b1;  err_addr = 9'd2;  err_op = 1;  err_rep = 1'b1;
        run_scn(3, 24, -1, -1, 0, -1);

        err_addr = 9'd1;  err_op = 1;  err_rep = 1'b0;
        run_scn(4, 11, 8, -1, 0, -1);

        err_en = 1'b0;
        run_scn(5, 26, -1, 5, 5, -1);

        err_en = 1'b1;  err_addr = 9'd2;  err_op = 1;  err_rep = 1'b1;
        run_scn(6, 20, -1, -1, 0, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

- Sequencing FSM that drives one MBIST memory port through a complete march test.
- It controls the operation selector through `run` and `re_init`, and steps the stimulus index through the march elements.
- It generates the up/down test address, handles element repeat, and applies repair-driven re-runs.
- It sits between the BIST top-level start/status registers and the per-memory operation selector, address mux and comparator.

## Interface
Parameters:
- `BIST_ADDR_WD`, 9, address width
- `BIST_ADDR_START`, 9'h000, first test address
- `BIST_ADDR_END`, 9'h1F8, last test address
- `BIST_STI_CNT`, 5, number of march elements
- `BIST_OP_SIZE`, 4, operations per element per address

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `bist_start`  in  1  single-cycle start pulse
- `scan_shift`  in  1  scan-shift mode; freezes the FSM
- `last_op`  in  1  current operation is the element's final op
- `op_updown`  in  1  direction of the current element: 1 = ascending, 0 = descending
- `op_repeatflag`  in  1  run the current element twice
- `cmp_err`  in  1  read compare mismatch this cycle
- `repair_ok`  in  1  repair logic absorbed the failing address
- `run`  out  1  advance the operation selector
- `re_init`  out  1  rewind the operation selector to op 0
- `sti_idx`  out  $clog2(BIST_STI_CNT)  march element index
- `bist_addr`  out  BIST_ADDR_WD  test address
- `bist_done`  out  1  test finished, sticky
- `bist_correct`  out  1  at least one repair occurred, sticky
- `bist_error`  out  1  unrepairable failure, sticky

## Operation
- Reset values:
  - state IDLE
  - `run` = 0, `re_init` = 0
  - `sti_idx` = 0
  - `bist_addr` = `BIST_ADDR_START`
  - `repeat_pass` = 0
  - all three status flags = 0
- States: IDLE, INIT, RUN, REPAIR, DONE.
- IDLE: `bist_start` → INIT; `sti_idx` ← 0; status flags cleared.
- INIT (1 cycle):
  - `run` = 0.
  - `bist_addr` ← `BIST_ADDR_START` if `op_updown` = 1, else `BIST_ADDR_END`.
  - → RUN.
- RUN: `run` = 1 every cycle (one op per cycle). Evaluated in priority order:
  1. `cmp_err` & `repair_ok` → REPAIR; `bist_correct` ← 1.
  2. `cmp_err` & !`repair_ok` → DONE; `bist_error` ← 1.
  3. `last_op` & address not at element boundary → `bist_addr` ± 1 (per `op_updown`); stay in RUN.
  4. `last_op` & at boundary (up: `BIST_ADDR_END`; down: `BIST_ADDR_START`):
     - if `op_repeatflag` & !`repeat_pass`: `repeat_pass` ← 1; → INIT, same `sti_idx`.
     - else if `sti_idx` = `BIST_STI_CNT`-1: → DONE.
     - else: `sti_idx` ← `sti_idx`+1; `repeat_pass` ← 0; → INIT.
- REPAIR (1 cycle):
  - `run` = 0, `re_init` = 1.
  - `bist_addr` unchanged.
  - → RUN, which re-executes the same address from op 0.
- DONE: `bist_done` = 1. `bist_start` → clears all three flags, `sti_idx` ← 0, → INIT. Flags hold otherwise.
- `bist_start` outside IDLE/DONE is ignored.
- `scan_shift` = 1: state and registers frozen; `run` = 0 and `re_init` = 0 forced.
- `rst` mid-test returns everything to reset values immediately (asynchronous).

## Timing
- `run` and `re_init` are combinational decodes of the state and `scan_shift`. All other outputs are registered.
- `bist_start` sampled at edge N → INIT during cycle N+1; first `run` in cycle N+2.
- Element cost: 1 INIT cycle + (addresses × `BIST_OP_SIZE`) RUN cycles.
- Address wrap is never used: boundary detection ends the element before the counter can overflow.
- `cmp_err` coincident with `last_op`: the error wins, and the address is re-run rather than advanced.
- Each repair adds exactly 1 + `BIST_OP_SIZE` cycles.

## Structure
- State enum typedef and the `BIST_STI_CNT`-derived index width go in the shared MBIST definitions package, next to `BIST_OP_SIZE` and `BIST_STI_WD`.
- One sub-module, `mbist_addr_gen`: loadable up/down counter with start/end boundary flag.
- The FSM, repeat flag and status flags stay in the top module.

## Test plan
Bench parameters: START=0, END=3, STI_CNT=2, OP_SIZE=2, `last_op` modelled on alternate RUN cycles.
- Clean run, both elements ascending, `bist_start` at cycle 0 → INIT cycles 1 and 10; RUN 2–9 and 11–18 with addresses 0,0,1,1,2,2,3,3; `bist_done` = 1 at cycle 19; `bist_error` = 0.
- Element 1 descending → addresses 3,3,2,2,1,1,0,0 during element 1; `sti_idx` = 1 from cycle 10.
- Element 0 with `op_repeatflag` = 1 → element 0 runs twice (INIT at 1 and 10); element 1 INIT at 19; done at 28.
- `cmp_err` = 1, `repair_ok` = 1 at address 2, op 1 → one REPAIR cycle with `re_init` = 1; address 2 re-run from op 0; `bist_correct` = 1; done 3 cycles late.
- `cmp_err` = 1, `repair_ok` = 0 at address 1 → next cycle DONE with `bist_error` = 1, `bist_done` = 1, `run` = 0.
- `scan_shift` held 5 cycles mid-RUN → `run` = 0 and `bist_addr` frozen; resumes identically afterwards. `rst` pulse mid-RUN → all outputs at reset values within the same cycle.
